// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, special encodings, flag layout, squarer states.
package fpu_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned E_W    = 11;

  typedef enum logic [RM_W-1:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] PINF = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] MAXF = 32'h7F7F_FFFF;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MUL   = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/seq_mant_mult.sv
// Iterative 24x24 shift-add significand multiplier, one multiplier bit per cycle.
module seq_mant_mult
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MANT_W-1:0] op_i,
  output logic              done_o,
  output logic [PROD_W-1:0] product_o
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned LAST  = MANT_W - 1;

  logic [MANT_W-1:0] mcand_q,  mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              run_q,    run_d;
  logic              done_q,   done_d;

  // Load on start, otherwise accumulate one partial product per cycle.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start_i) begin
      mcand_d  = op_i;
      mplier_d = op_i;
      acc_d    = '0;
      count_d  = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[count_q]) begin
        acc_d = acc_q + (PROD_W'(mcand_q) << count_q);
      end
      count_d = count_q + CNT_W'(1);
      if (count_q == CNT_W'(LAST)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/fp_square_seq.sv
// Sequential single-precision squarer y = a*a with start/valid handshake.
module fp_square_seq
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [RM_W-1:0]   rounding_mode,
  input  logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] y,
  output logic [FLAG_W-1:0] FPU_flags,
  output logic              valid,
  output logic              busy
);

  state_t state_q, state_d;

  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-2:0] man_q;
  logic [RM_W-1:0]   rm_q;

  logic [WORD_W-1:0] y_q, y_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              capture_c;
  logic              mul_done;
  logic [PROD_W-1:0] prod;
  logic [MANT_W-1:0] mul_op_c;

  // The operand sign never affects a square.
  logic unused_sign_c;
  assign unused_sign_c = a[WORD_W-1];

  assign mul_op_c = {(a[30:23] != '0), a[22:0]};

  seq_mant_mult u_mult (
    .clk      (clk),
    .rst      (rst),
    .start_i  (capture_c),
    .op_i     (mul_op_c),
    .done_o   (mul_done),
    .product_o(prod)
  );

  logic              exp_max_c, exp_zero_c, man_zero_c;
  logic [MANT_W-2:0] mant_c, mant_fin_c;
  logic [MANT_W-1:0] mant_rnd_c;
  logic              g_c, s_c, rnd_inc_c, trunc_mode_c;
  logic signed [E_W-1:0] e_pre_c, e_post_c;
  logic [WORD_W-1:0] res_y_c;
  logic [FLAG_W-1:0] res_flags_c;

  // Normalise, round and classify; only consumed in ROUND.
  always_comb begin
    exp_max_c  = (exp_q == '1);
    exp_zero_c = (exp_q == '0);
    man_zero_c = (man_q == '0);

    if (prod[PROD_W-1]) begin
      mant_c = prod[46:24];
      g_c    = prod[23];
      s_c    = |prod[22:0];
    end else begin
      mant_c = prod[45:23];
      g_c    = prod[22];
      s_c    = |prod[21:0];
    end

    e_pre_c = $signed(E_W'({exp_q, 1'b0})) - $signed(E_W'(BIAS))
            + $signed(E_W'(prod[PROD_W-1]));

    case (rm_q)
      RM_RTZ:  rnd_inc_c = 1'b0;
      RM_RDN:  rnd_inc_c = 1'b0;
      RM_RUP:  rnd_inc_c = g_c | s_c;
      RM_RMM:  rnd_inc_c = g_c;
      default: rnd_inc_c = g_c & (s_c | mant_c[0]);
    endcase
    trunc_mode_c = (rm_q == RM_RTZ) || (rm_q == RM_RDN);

    mant_rnd_c = {1'b0, mant_c} + MANT_W'(rnd_inc_c);
    mant_fin_c = mant_rnd_c[MANT_W-2:0];
    e_post_c   = mant_rnd_c[MANT_W-1] ? (e_pre_c + E_W'(1)) : e_pre_c;

    res_y_c     = '0;
    res_flags_c = '0;
    if (exp_max_c) begin
      if (!man_zero_c) begin
        res_y_c              = QNAN;
        res_flags_c[FLAG_NV] = ~man_q[MANT_W-2];
      end else begin
        res_y_c = PINF;
      end
    end else if (exp_zero_c) begin
      if (!man_zero_c) begin
        res_flags_c[FLAG_UF] = 1'b1;
        res_flags_c[FLAG_NX] = 1'b1;
      end
    end else if (e_pre_c <= $signed(E_W'(0))) begin
      res_flags_c[FLAG_UF] = 1'b1;
      res_flags_c[FLAG_NX] = 1'b1;
    end else if (e_post_c >= $signed(E_W'(255))) begin
      res_y_c              = trunc_mode_c ? MAXF : PINF;
      res_flags_c[FLAG_OF] = 1'b1;
      res_flags_c[FLAG_NX] = 1'b1;
    end else begin
      res_y_c              = {1'b0, e_post_c[EXP_W-1:0], mant_fin_c};
      res_flags_c[FLAG_NX] = g_c | s_c;
    end
    res_flags_c[FLAG_DZ] = 1'b0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    flags_d   = flags_q;
    valid_d   = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          capture_c = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        y_d     = res_y_c;
        flags_d = res_flags_c;
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Operand capture at start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= '0;
      man_q <= '0;
      rm_q  <= '0;
    end else if (capture_c) begin
      exp_q <= a[30:23];
      man_q <= a[22:0];
      rm_q  <= rounding_mode;
    end
  end

  assign y         = y_q;
  assign FPU_flags = flags_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_square_seq.sv
// Directed self-checking bench for fp_square_seq.
module tb_fp_square_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [2:0]  rounding_mode;
  logic [31:0] a;
  logic [31:0] y;
  logic [4:0]  FPU_flags;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp_square_seq dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .rounding_mode(rounding_mode),
    .a            (a),
    .y            (y),
    .FPU_flags    (FPU_flags),
    .valid        (valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Start one operation and wait (bounded) for its valid pulse.
  task automatic run_op(input logic [31:0] av, input logic [2:0] rmv,
                        output logic [31:0] yo, output logic [4:0] fo,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    a = av; rounding_mode = rmv; ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    lat = 0; busy_ok = 1'b1; yo = 32'hDEAD_BEEF; fo = 5'h1F;
    if (busy !== 1'b1) busy_ok = 1'b0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (valid === 1'b1) begin
        yo = y; fo = FPU_flags;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; ready = 1'b0; a = '0; rounding_mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h expected %h", y, 32'h0); end
    checks++; if (FPU_flags !== 5'h0) begin errors++; $display("FAIL reset_flags got %b expected %b", FPU_flags, 5'h0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] yv; logic [4:0] fv; int lat; bit bok;
    run_op(32'h4040_0000, 3'b000, yv, fv, lat, bok);
    checks++; if (yv !== 32'h4110_0000) begin errors++; $display("FAIL basic_y got %h expected %h", yv, 32'h4110_0000); end
    checks++; if (fv !== 5'b00000) begin errors++; $display("FAIL basic_flags got %b expected %b", fv, 5'b00000); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL basic_latency got %0d expected 26", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy_held got %b expected 1", bok); end
    @(posedge clk); @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_ignore_ready;
    logic [31:0] yv; logic [4:0] fv; int lat; int extra; bit seen; bit idle_ok;
    @(negedge clk);
    a = 32'hC000_0000; rounding_mode = 3'b000; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    lat = 0; seen = 1'b0; yv = 32'hDEAD_BEEF; fv = 5'h1F;
    while (lat < 40 && !seen) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 5) begin a = 32'h3F80_0000; ready = 1'b1; end
      else ready = 1'b0;
      if (valid === 1'b1) begin seen = 1'b1; yv = y; fv = FPU_flags; end
    end
    checks++; if (yv !== 32'h4080_0000) begin errors++; $display("FAIL ignore_y got %h expected %h", yv, 32'h4080_0000); end
    checks++; if (fv !== 5'b00000) begin errors++; $display("FAIL ignore_flags got %b expected %b", fv, 5'b00000); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL ignore_latency got %0d expected 26", lat); end
    // ready raised during the DONE cycle must not start anything.
    a = 32'h3F80_0000; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    extra = 0; idle_ok = 1'b1;
    repeat (35) begin
      if (busy !== 1'b0) idle_ok = 1'b0;
      if (valid === 1'b1) extra++;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_valid got %0d expected 0", extra); end
    checks++; if (idle_ok !== 1'b1) begin errors++; $display("FAIL ignore_done_start got busy expected idle"); end
  endtask

  task automatic test_rounding;
    logic [31:0] va [0:9] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0001,
                              32'h3F80_0001, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3F80_0800,
                              32'h3F80_0800, 32'h3F80_0800};
    logic [2:0]  vr [0:9] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b111,
                              3'b000, 3'b011, 3'b000, 3'b100, 3'b001};
    logic [31:0] vy [0:9] = '{32'h3F80_0002, 32'h3F80_0003, 32'h3F80_0002, 32'h3F80_0002,
                              32'h3F80_0002, 32'h407F_FFFE, 32'h407F_FFFF, 32'h3F80_1000,
                              32'h3F80_1001, 32'h3F80_1000};
    logic [31:0] yv; logic [4:0] fv; int lat; bit bok;
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vr[i], yv, fv, lat, bok);
      checks++; if (yv !== vy[i]) begin errors++; $display("FAIL round_y[%0d] got %h expected %h", i, yv, vy[i]); end
      checks++; if (fv !== 5'b00001) begin errors++; $display("FAIL round_flags[%0d] got %b expected %b", i, fv, 5'b00001); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] yv; logic [4:0] fv; int lat; bit bok;
    run_op(32'h4040_0000, 3'b000, yv, fv, lat, bok);
    checks++; if (yv !== 32'h4110_0000) begin errors++; $display("FAIL b2b_first_y got %h expected %h", yv, 32'h4110_0000); end
    run_op(32'hC000_0000, 3'b000, yv, fv, lat, bok);
    checks++; if (yv !== 32'h4080_0000) begin errors++; $display("FAIL b2b_second_y got %h expected %h", yv, 32'h4080_0000); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL b2b_second_latency got %0d expected 26", lat); end
  endtask

  task automatic test_specials;
    logic [31:0] va [0:11] = '{32'h5F80_0000, 32'h5F80_0000, 32'h5F80_0000, 32'h1F80_0000,
                               32'h7F80_0001, 32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000,
                               32'h0000_0001, 32'h5F00_0000, 32'h2000_0000, 32'h5F80_0000};
    logic [2:0]  vr [0:11] = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b000, 3'b000,
                               3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [31:0] vy [0:11] = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h0000_0000,
                               32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000,
                               32'h0000_0000, 32'h7E80_0000, 32'h0080_0000, 32'h7F80_0000};
    logic [4:0]  vf [0:11] = '{5'b00101, 5'b00101, 5'b00101, 5'b00011, 5'b10000, 5'b00000,
                               5'b00000, 5'b00000, 5'b00011, 5'b00000, 5'b00000, 5'b00101};
    logic [31:0] yv; logic [4:0] fv; int lat; bit bok;
    for (int i = 0; i < 12; i++) begin
      run_op(va[i], vr[i], yv, fv, lat, bok);
      checks++; if (yv !== vy[i]) begin errors++; $display("FAIL special_y[%0d] got %h expected %h", i, yv, vy[i]); end
      checks++; if (fv !== vf[i]) begin errors++; $display("FAIL special_flags[%0d] got %b expected %b", i, fv, vf[i]); end
      checks++; if (lat !== 26) begin errors++; $display("FAIL special_latency[%0d] got %0d expected 26", i, lat); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] yv; logic [4:0] fv; int lat; bit bok; int extra;
    @(negedge clk);
    a = 32'h4040_0000; rounding_mode = 3'b000; ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL midrst_y got %h expected %h", y, 32'h0); end
    checks++; if (FPU_flags !== 5'h0) begin errors++; $display("FAIL midrst_flags got %b expected %b", FPU_flags, 5'h0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    rst = 1'b1;
    extra = 0;
    repeat (35) begin
      @(posedge clk); @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL midrst_no_result got %0d active cycles expected 0", extra); end
    run_op(32'h3F80_0001, 3'b011, yv, fv, lat, bok);
    checks++; if (yv !== 32'h3F80_0003) begin errors++; $display("FAIL midrst_restart_y got %h expected %h", yv, 32'h3F80_0003); end
    checks++; if (fv !== 5'b00001) begin errors++; $display("FAIL midrst_restart_flags got %b expected %b", fv, 5'b00001); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL midrst_restart_latency got %0d expected 26", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_ready();
    test_rounding();
    test_back_to_back();
    test_specials();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1);
  end

endmodule
